// File: rtl/treehash_ctrl_pkg.sv
// Shared definitions for the XMSS treehash controller.
// Holds the key width, the hash-tree address type code, the address word
// offsets, the state encoding, and the helper that builds a hash-tree address.
`ifndef XMSS_HASH_PADDING_DEFS
`define XMSS_HASH_PADDING_DEFS
`define XMSS_HASH_PADDING_F    32'd0
`define XMSS_HASH_PADDING_H    32'd1
`define XMSS_HASH_PADDING_HASH 32'd2
`define XMSS_HASH_PADDING_PRF  32'd3
`endif

package treehash_ctrl_pkg;

  localparam int KEY_LEN = 256;

  localparam logic [31:0] ADDR_TYPE_HASHTREE = 32'd2;

  localparam int ADDR_W_TYPE   = 3;
  localparam int ADDR_W_HEIGHT = 5;
  localparam int ADDR_W_INDEX  = 6;
  localparam int ADDR_W_KM     = 7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LEAF  = 3'd1,
    ST_CHECK      = 3'd2,
    ST_HASH_START = 3'd3,
    ST_HASH_WAIT  = 3'd4,
    ST_FINISH     = 3'd5
  } th_state_e;

  // Word k sits at bits [255-32k -: 32]. Words 0..2 (layer, tree) pass
  // through from base; words 3..7 are rebuilt for a hash-tree node.
  function automatic logic [255:0] hash_addr(input logic [255:0] base,
                                             input logic [31:0]  height,
                                             input logic [31:0]  index);
    logic [255:0] a;
    a = base;
    a[255-32*ADDR_W_TYPE   -: 32] = ADDR_TYPE_HASHTREE;
    a[255-32*4             -: 32] = 32'd0;
    a[255-32*ADDR_W_HEIGHT -: 32] = height;
    a[255-32*ADDR_W_INDEX  -: 32] = index;
    a[255-32*ADDR_W_KM     -: 32] = 32'd0;
    return a;
  endfunction

endpackage

// File: rtl/treehash_ctrl_node_stack.sv
// LIFO of {node, height} entries used by the treehash controller.
// Ports: clear empties the stack; push appends {push_node, push_height};
// pop2_push atomically replaces the two top entries with one new entry.
// top_*/second_* expose the two uppermost entries, sp is the entry count.
module node_stack #(
  parameter int KEY_LEN = 256,
  parameter int DEPTH   = 5,
  parameter int HW      = 5,
  parameter int SPW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop2_push,
  input  logic [KEY_LEN-1:0] push_node,
  input  logic [HW-1:0]      push_height,
  output logic [KEY_LEN-1:0] top_node,
  output logic [HW-1:0]      top_height,
  output logic [KEY_LEN-1:0] second_node,
  output logic [HW-1:0]      second_height,
  output logic [SPW-1:0]     sp
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1'b1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2'd2);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [KEY_LEN-1:0] node_r   [DEPTH];
  logic [HW-1:0]      height_r [DEPTH];
  logic [SPW-1:0]     sp_r;
  logic [SPW-1:0]     sp_next_s;
  logic               wr_en_s;
  logic [IW-1:0]      wr_idx_s;
  logic [IW-1:0]      top_idx_s;
  logic [IW-1:0]      second_idx_s;

  // Write slot and next pointer; a merge writes where the lower operand was.
  always_comb begin
    sp_next_s = sp_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = {IW{1'b0}};
    if (clear) begin
      sp_next_s = {SPW{1'b0}};
    end else if (push && (sp_r != SP_FULL)) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = IW'(sp_r);
      sp_next_s = sp_r + SP_ONE;
    end else if (pop2_push && (sp_r >= SP_TWO)) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = IW'(sp_r - SP_TWO);
      sp_next_s = sp_r - SP_ONE;
    end else begin
      sp_next_s = sp_r;
    end
  end

  // Read indices of the two uppermost entries, clamped while the stack is shallow.
  always_comb begin
    top_idx_s    = (sp_r >= SP_ONE) ? IW'(sp_r - SP_ONE) : {IW{1'b0}};
    second_idx_s = (sp_r >= SP_TWO) ? IW'(sp_r - SP_TWO) : {IW{1'b0}};
  end

  // Stack pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= {SPW{1'b0}};
    end else begin
      sp_r <= sp_next_s;
    end
  end

  // Entry storage; contents are meaningless above sp so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      node_r[wr_idx_s]   <= push_node;
      height_r[wr_idx_s] <= push_height;
    end
  end

  assign top_node      = node_r[top_idx_s];
  assign top_height    = height_r[top_idx_s];
  assign second_node   = node_r[second_idx_s];
  assign second_height = height_r[second_idx_s];
  assign sp            = sp_r;

endmodule

// File: rtl/treehash_ctrl.sv
// Merkle treehash controller: accepts 2^TREE_HEIGHT leaves serially, merges
// equal-height stack entries through thash_h, and reports the subtree root.
// Ports: start/pub_seed/base_addr begin a run; leaf_valid/leaf_ready/leaf_data
// form the leaf handshake; thash_* drive and return from thash_h; root/done/
// busy report completion. reset is asynchronous and active low.
module treehash_ctrl #(
  parameter int KEY_LEN     = 256,
  parameter int TREE_HEIGHT = 4,
  parameter int HW          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_LEN-1:0]   pub_seed,
  input  logic [255:0]         base_addr,
  input  logic                 leaf_valid,
  output logic                 leaf_ready,
  input  logic [KEY_LEN-1:0]   leaf_data,
  output logic                 thash_start,
  output logic [KEY_LEN-1:0]   thash_input_key,
  output logic [2*KEY_LEN-1:0] thash_input_data,
  output logic [255:0]         thash_hash_addr,
  input  logic                 thash_done,
  input  logic [KEY_LEN-1:0]   thash_data_out,
  output logic [KEY_LEN-1:0]   root,
  output logic                 done,
  output logic                 busy
);

  import treehash_ctrl_pkg::*;

  localparam int DEPTH = TREE_HEIGHT + 1;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int CW    = TREE_HEIGHT + 1;
  localparam logic [CW-1:0]  LEAF_TOTAL = {1'b1, {TREE_HEIGHT{1'b0}}};
  localparam logic [CW-1:0]  CNT_ONE    = {{TREE_HEIGHT{1'b0}}, 1'b1};
  localparam logic [HW-1:0]  HEIGHT_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [SPW-1:0] SP_TWO     = SPW'(2'd2);

  th_state_e state_r, state_next_s;

  logic [CW-1:0]        leaf_cnt_r;
  logic [KEY_LEN-1:0]   key_r;
  logic [255:0]         base_r;
  logic [2*KEY_LEN-1:0] data_r;
  logic [255:0]         addr_r;
  logic [KEY_LEN-1:0]   root_r;
  logic                 leaf_ready_r, thash_start_r, done_r, busy_r;

  logic                 stk_clear_s, stk_push_s, stk_pop2_s;
  logic [KEY_LEN-1:0]   stk_node_s;
  logic [HW-1:0]        stk_height_s;
  logic [KEY_LEN-1:0]   top_node_s, second_node_s;
  logic [HW-1:0]        top_height_s, second_height_s;
  logic [SPW-1:0]       sp_s;
  logic                 pair_ready_s, leaf_done_s;
  logic [31:0]          merge_index_s;

  node_stack #(
    .KEY_LEN(KEY_LEN),
    .DEPTH  (DEPTH),
    .HW     (HW),
    .SPW    (SPW)
  ) u_stack (
    .clk          (clk),
    .rst_n        (reset),
    .clear        (stk_clear_s),
    .push         (stk_push_s),
    .pop2_push    (stk_pop2_s),
    .push_node    (stk_node_s),
    .push_height  (stk_height_s),
    .top_node     (top_node_s),
    .top_height   (top_height_s),
    .second_node  (second_node_s),
    .second_height(second_height_s),
    .sp           (sp_s)
  );

  // Merge decision and the node index of the parent: the last leaf consumed
  // lies under the merged subtree, so its index shifted by h+1 names the parent.
  always_comb begin
    pair_ready_s  = (sp_s >= SP_TWO) && (top_height_s == second_height_s);
    leaf_done_s   = (leaf_cnt_r == LEAF_TOTAL);
    merge_index_s = (32'(leaf_cnt_r) - 32'd1) >> (32'(top_height_s) + 32'd1);
  end

  // Next-state and stack control.
  always_comb begin
    state_next_s = state_r;
    stk_clear_s  = 1'b0;
    stk_push_s   = 1'b0;
    stk_pop2_s   = 1'b0;
    stk_node_s   = leaf_data;
    stk_height_s = {HW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          stk_clear_s  = 1'b1;
          state_next_s = ST_WAIT_LEAF;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_LEAF: begin
        if (leaf_valid) begin
          stk_push_s   = 1'b1;
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_WAIT_LEAF;
        end
      end
      ST_CHECK: begin
        if (pair_ready_s) begin
          state_next_s = ST_HASH_START;
        end else if (leaf_done_s) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_WAIT_LEAF;
        end
      end
      ST_HASH_START: begin
        state_next_s = ST_HASH_WAIT;
      end
      ST_HASH_WAIT: begin
        if (thash_done) begin
          stk_pop2_s   = 1'b1;
          stk_node_s   = thash_data_out;
          stk_height_s = top_height_s + HEIGHT_ONE;
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_HASH_WAIT;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      leaf_ready_r  <= 1'b0;
      thash_start_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      leaf_ready_r  <= (state_next_s == ST_WAIT_LEAF);
      thash_start_r <= (state_next_s == ST_HASH_START);
      done_r        <= (state_next_s == ST_FINISH);
      busy_r        <= (state_next_s == ST_WAIT_LEAF) || (state_next_s == ST_CHECK) ||
                       (state_next_s == ST_HASH_START) || (state_next_s == ST_HASH_WAIT);
    end
  end

  // Run context, merge operands/address and the root register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leaf_cnt_r <= {CW{1'b0}};
      key_r      <= {KEY_LEN{1'b0}};
      base_r     <= 256'd0;
      data_r     <= {(2*KEY_LEN){1'b0}};
      addr_r     <= 256'd0;
      root_r     <= {KEY_LEN{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && start) begin
        leaf_cnt_r <= {CW{1'b0}};
        key_r      <= pub_seed;
        base_r     <= base_addr;
      end else if (stk_push_s) begin
        leaf_cnt_r <= leaf_cnt_r + CNT_ONE;
      end
      // Operands and address are captured once and then held through HASH_WAIT.
      if ((state_r == ST_CHECK) && pair_ready_s) begin
        data_r <= {second_node_s, top_node_s};
        addr_r <= hash_addr(base_r, 32'(top_height_s), merge_index_s);
      end
      // Loaded on the way into FINISH so root is already valid with done.
      if ((state_r == ST_CHECK) && !pair_ready_s && leaf_done_s) begin
        root_r <= top_node_s;
      end
    end
  end

  assign leaf_ready       = leaf_ready_r;
  assign thash_start      = thash_start_r;
  assign thash_input_key  = key_r;
  assign thash_input_data = data_r;
  assign thash_hash_addr  = addr_r;
  assign root             = root_r;
  assign done             = done_r;
  assign busy             = busy_r;

endmodule

// File: doc/treehash_ctrl.md
Name: treehash_ctrl

Overview:
- Merkle treehash controller for the XMSS hardware core.
- Consumes WOTS/L-tree leaf nodes serially, keeps the node stack, and drives the thash_h interface for every node merge.
- Sits directly upstream of thash_h and produces the subtree root of height TREE_HEIGHT.
- Total thash_h calls per tree: 2^TREE_HEIGHT - 1.

Parameters:
KEY_LEN, 256, node/key width in bits (n).
TREE_HEIGHT, 4, subtree height; must be >= 1; leaves per tree = 2^TREE_HEIGHT.
HW, 5, width of stored node heights and the height address field; must satisfy 2^HW > TREE_HEIGHT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; latches pub_seed and base_addr, clears the stack. Ignored while busy=1.
pub_seed  input  KEY_LEN  public seed, forwarded to thash_h as its key.
base_addr  input  256  XMSS address; words 0..2 (layer, tree) are used, words 3..7 are overridden.
leaf_valid  input  1  leaf_data valid.
leaf_ready  output  1  controller accepts a leaf this cycle.
leaf_data  input  KEY_LEN  leaf node.
thash_start  output  1  one-cycle start pulse to thash_h.
thash_input_key  output  KEY_LEN  latched pub_seed.
thash_input_data  output  2*KEY_LEN  {left, right}; left occupies the upper KEY_LEN bits.
thash_hash_addr  output  256  hash-tree address for the current merge.
thash_done  input  1  thash_h completion pulse.
thash_data_out  input  KEY_LEN  merged node from thash_h.
root  output  KEY_LEN  subtree root; valid from the done pulse until the next accepted start.
done  output  1  one-cycle pulse when root is valid.
busy  output  1  high from the accepted start until the done pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sp=0; leaf_cnt=0. All outputs read 0: leaf_ready, thash_start, thash_input_key, thash_input_data, thash_hash_addr, root, done, busy. Stack contents are don't-care.
- Reset mid-operation aborts immediately with no done pulse. thash_h shares the same reset.
- Address layout: word k = bits [255-32k -: 32].
  - Words 0..2 come from base_addr.
  - Word3 (type) = 2; word4 = 0; word5 = node height h; word6 = tree index; word7 = 0.
  - thash_h itself updates keyAndMask.
- Stack: TREE_HEIGHT+1 entries of KEY_LEN bits plus HW-bit heights; sp is the entry count.
- leaf_cnt: width TREE_HEIGHT+1.
- States:
  - IDLE: on start, go to WAIT_LEAF; busy=1.
  - WAIT_LEAF: leaf_ready=1. On leaf_valid, push {leaf_data, height 0}, increment leaf_cnt, go to CHECK. One cycle per accepted leaf.
  - CHECK (leaf_ready=0):
    - If sp>=2 and height[sp-1]==height[sp-2], go to HASH_START.
    - Else if leaf_cnt==2^TREE_HEIGHT (sp==1 is implied), go to FINISH.
    - Else go to WAIT_LEAF.
  - HASH_START: set thash_input_data={stack[sp-2], stack[sp-1]}. Set h=height[sp-1] and word6=(leaf_cnt-1)>>(h+1). Pulse thash_start for exactly 1 cycle, then go to HASH_WAIT.
  - HASH_WAIT: hold thash_input_data and thash_hash_addr stable. On thash_done: pop 2, push {thash_data_out, h+1}, go to CHECK.
  - FINISH: root<=stack[0]; done=1 for 1 cycle; busy drops the same cycle; go to IDLE.
- Boundary and ignore rules:
  - thash_done outside HASH_WAIT is ignored.
  - start while busy is ignored.
  - leaf_valid outside WAIT_LEAF is not accepted (backpressure).
  - Max stack occupancy is TREE_HEIGHT+1, reached after pushing the final leaf. Overflow cannot occur.
  - leaf_cnt reaching 2^TREE_HEIGHT stops leaf acceptance.
  - A new start after done re-latches inputs; root holds its old value until the first done of the new run.
- Latency per tree: 2^H leaf cycles + (2^H-1)*(2 + thash latency) + CHECK cycles + 1.

Decomposition:
- Shared package/header:
  - KEY_LEN.
  - ADDR_TYPE_HASHTREE=2.
  - Address word offset constants: ADDR_W_TYPE=3, ADDR_W_HEIGHT=5, ADDR_W_INDEX=6, ADDR_W_KM=7.
  - XMSS_HASH_PADDING_* defines, already shared with thash_h.
- Sub-module node_stack:
  - LIFO of {node, height}.
  - Signals: push, pop2_push (atomic pop-2-push-1), top/second outputs, sp.
  - The controller FSM stays in treehash_ctrl.

Test Plan (stub thash_h: 5-cycle latency, output = left+right mod 2^KEY_LEN, logs each start):
- TREE_HEIGHT=2, leaves 1,2,3,4 back-to-back -> 3 thash_start pulses with (height,index) = (0,0), (0,1), (1,0); type word = 2; root=10; done pulses once.
- TREE_HEIGHT=3, leaves 1..8 -> 7 hashes; last address (2,0); root=36; busy high throughout the run, low the cycle after done.
- Backpressure: leaf_valid held high continuously -> leaf_ready=0 in every CHECK/HASH cycle; exactly 4 leaves accepted for H=2; the extra valid is not consumed.
- Spurious thash_done during WAIT_LEAF and a start during HASH_WAIT -> no stack change, no restart; root still 10.
- reset asserted during the second HASH_WAIT -> all outputs 0 asynchronously; no done; a fresh start with leaves 5,6,7,8 -> root=26.
- Second start after done with base_addr words0..2 = 0x1,0x2,0x3 -> thash_hash_addr[255:160] = 0x00000001_00000002_00000003; root holds its old value until the new done.
